alu_issue_arb: RTL and testbench
================================

// Module: alu_issue_arb
// PURPOSE
//  Shares the single exe-stage alu among NUM_THR hardware thread contexts. Round-robin
//  arbitrates per-thread ALU requests, registers the winner's operands into an issue
//  register driving the combinational alu, captures the alu result plus eq/lt/overflow
//  into a response register tagged with the thread id, and applies valid/ready backpressure.
// PARAMETERS
//  NUM_THR  4                 number of requesting thread contexts (2..8)
//  TID_W    $clog2(NUM_THR)   thread id width (derived, do not override)
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              async active-low reset
//  req_valid  in   NUM_THR        per-thread request valid
//  req_ready  out  NUM_THR        per-thread accept (one-hot or zero)
//  req_a      in   NUM_THR x 32   per-thread Ain
//  req_b      in   NUM_THR x 32   per-thread Bin
//  req_imm    in   NUM_THR x 16   per-thread immediate
//  req_op     in   NUM_THR x 3    per-thread alu_op (header.svh encodings)
//  req_itype  in   NUM_THR        per-thread i_type
//  thr_en     in   NUM_THR        thread enabled; 0 masks that thread from arbitration
//  flush      in   NUM_THR        kill all in-flight ops of the flagged threads
//  alu_ain/alu_bin  out 32        to alu, from issue register
//  alu_imm    out  16             to alu;  alu_op out 3;  alu_itype out 1
//  alu_out    in   32             from alu; alu_eq, alu_lt, alu_ovf in 1 each
//  rsp_valid  out  1              response valid
//  rsp_ready  in   1              consumer accepts response
//  rsp_tid    out  TID_W          thread owning the response
//  rsp_data   out  32             alu result; rsp_eq, rsp_lt, rsp_ovf out 1 each
// BEHAVIOUR
//  - Reset: issue/response valids 0, rr pointer 0, rsp_* data 0, alu_* driven 0, req_ready 0.
//  - Pipeline: S1 issue reg (iss_v, tid, a, b, imm, op, itype) -> alu -> S2 response reg.
//  - advance = ~rsp_valid | rsp_ready. S2 loads S1 (and alu results) when advance.
//    S1 loads a new grant when ~iss_v | advance; else S1 holds and no grant issues.
//  - Latency: request accepted in cycle N -> rsp_valid in N+2 with no backpressure.
//    Throughput 1 op/cycle sustained.
//  - Arbitration: eligible = req_valid & thr_en & ~flush. Grant the first eligible thread
//    at or after rr_ptr (wrapping NUM_THR-1 -> 0). req_ready[g]=1 only if S1 can load.
//    On accepted grant rr_ptr <= g+1 (mod NUM_THR); no grant -> rr_ptr holds.
//  - Flush: flush[t] clears iss_v if S1 tid==t and rsp_valid if S2 tid==t, same edge;
//    flush beats an S1->S2 transfer of that tid (entry dropped). Other threads unaffected.
//  - Response reg holds stable while rsp_valid & ~rsp_ready.
//  - rsp_ovf = alu_ovf captured verbatim (only meaningful for ADD); rsp_eq/lt captured
//    for every op; consumer decides use.
//  - Idle alu inputs: alu_* hold last issued value (no toggling requirement).
//  - Reset asserted mid-operation: all in-flight entries discarded, no response emitted.
//  - Invalid req_op values are passed through; alu yields 0.
// STRUCTURE
//  - header.svh: alu_op constants (ADD, AND, OR, XOR, NOT, SHLT, SHRT, SHAR),
//    NUM_THR default, tid_t typedef, alu_req_t packed struct {a,b,imm,op,itype}.
//  - Sub-module rr_arbiter #(N) (req, ptr -> one-hot gnt, gnt_idx, any); reused elsewhere.
//  - alu instantiated outside; this block owns only arbitration and the two registers.
// TESTING
//  1 Single op: t2 ADD a=5 b=7 -> rsp_valid 2 cycles later, tid=2, data=12, eq=0, lt=1.
//  2 All 4 threads request continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle.
//  3 Backpressure: rsp_ready=0 for 3 cycles with 2 ops in flight -> rsp stable, req_ready
//    all 0, no op lost; release -> both responses in order.
//  4 Flush: t1 op in S1, t3 op in S2, flush=4'b0010 -> t1 op never responds, t3 unaffected.
//  5 thr_en=4'b1011, all valid -> t2 never granted; rr order 0,1,3,0.
//  6 ADD a=32'h7FFFFFFF b=1 -> data 32'h80000000, rsp_ovf=1; assert rst_n mid-flight ->
//    rsp_valid 0 next cycle, rr_ptr 0.

Source files
------------

// File: rtl/alu_issue_arb_pkg.sv
// Shared types and constants for the ALU issue arbiter.
package alu_issue_arb_pkg;

    localparam int unsigned NumThrDefault = 4;
    localparam int unsigned DataW         = 32;
    localparam int unsigned ImmW          = 16;
    localparam int unsigned OpW           = 3;

    // ALU operation encodings
    typedef enum logic [OpW-1:0] {
        AluAdd  = 3'd0,
        AluAnd  = 3'd1,
        AluOr   = 3'd2,
        AluXor  = 3'd3,
        AluNot  = 3'd4,
        AluShlt = 3'd5,
        AluShrt = 3'd6,
        AluShar = 3'd7
    } alu_op_e;

    typedef logic [$clog2(NumThrDefault)-1:0] tid_t;

    // Op is kept as raw bits so unknown encodings pass through untouched.
    typedef struct packed {
        logic [DataW-1:0] a;
        logic [DataW-1:0] b;
        logic [ImmW-1:0]  imm;
        logic [OpW-1:0]   op;
        logic             itype;
    } alu_req_t;

endpackage

// File: rtl/alu_issue_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module alu_issue_arb_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            any_o
);

    logic [IdxW-1:0] idx;

    // Scan from ptr_i upward; the first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IdxW'((32'(ptr_i) + i) % N);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arb.sv
// Shares one ALU among NUM_THR thread contexts: round-robin issue register (S1)
// feeding the external ALU, and a tagged response register (S2) with backpressure.
module alu_issue_arb
    import alu_issue_arb_pkg::*;
#(
    parameter int unsigned NUM_THR = NumThrDefault,
    parameter int unsigned TID_W   = $clog2(NUM_THR)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_THR-1:0]            req_valid,
    output logic [NUM_THR-1:0]            req_ready,
    input  logic [NUM_THR-1:0][DataW-1:0] req_a,
    input  logic [NUM_THR-1:0][DataW-1:0] req_b,
    input  logic [NUM_THR-1:0][ImmW-1:0]  req_imm,
    input  logic [NUM_THR-1:0][OpW-1:0]   req_op,
    input  logic [NUM_THR-1:0]            req_itype,
    input  logic [NUM_THR-1:0]            thr_en,
    input  logic [NUM_THR-1:0]            flush,
    output logic [DataW-1:0]              alu_ain,
    output logic [DataW-1:0]              alu_bin,
    output logic [ImmW-1:0]               alu_imm,
    output logic [OpW-1:0]                alu_op,
    output logic                          alu_itype,
    input  logic [DataW-1:0]              alu_out,
    input  logic                          alu_eq,
    input  logic                          alu_lt,
    input  logic                          alu_ovf,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [TID_W-1:0]              rsp_tid,
    output logic [DataW-1:0]              rsp_data,
    output logic                          rsp_eq,
    output logic                          rsp_lt,
    output logic                          rsp_ovf
);

    // S1 issue register
    logic             iss_v_q, iss_v_d;
    logic [TID_W-1:0] iss_tid_q, iss_tid_d;
    alu_req_t         iss_req_q, iss_req_d;

    // S2 response register
    logic             rsp_valid_q, rsp_valid_d;
    logic [TID_W-1:0] rsp_tid_q, rsp_tid_d;
    logic [DataW-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_eq_q, rsp_eq_d;
    logic             rsp_lt_q, rsp_lt_d;
    logic             rsp_ovf_q, rsp_ovf_d;

    logic [TID_W-1:0] rr_ptr_q, rr_ptr_d;
    // Low in reset and for the first cycle after release, so req_ready stays 0 in reset.
    logic             run_q, run_d;

    logic [NUM_THR-1:0] eligible;
    logic [NUM_THR-1:0] gnt;
    logic [TID_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               advance;
    logic               s1_load;
    logic               accept;
    logic               iss_kill;
    logic               rsp_kill;
    alu_req_t           win_req;

    assign eligible = req_valid & thr_en & ~flush;

    alu_issue_arb_rr_arbiter #(
        .N    (NUM_THR),
        .IdxW (TID_W)
    ) u_rr_arbiter (
        .req_i     (eligible),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    // Handshake decode: S2 drains or is empty -> everything moves.
    always_comb begin
        advance   = ~rsp_valid_q | rsp_ready;
        s1_load   = (~iss_v_q | advance) & run_q;
        accept    = gnt_any & s1_load;
        req_ready = s1_load ? gnt : '0;
        iss_kill  = iss_v_q & flush[iss_tid_q];
        rsp_kill  = rsp_valid_q & flush[rsp_tid_q];
        win_req   = '{a:     req_a[gnt_idx],
                      b:     req_b[gnt_idx],
                      imm:   req_imm[gnt_idx],
                      op:    req_op[gnt_idx],
                      itype: req_itype[gnt_idx]};
    end

    // Next-state for both pipeline registers and the round-robin pointer.
    always_comb begin
        iss_v_d     = iss_v_q;
        iss_tid_d   = iss_tid_q;
        iss_req_d   = iss_req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_tid_d   = rsp_tid_q;
        rsp_data_d  = rsp_data_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_lt_d    = rsp_lt_q;
        rsp_ovf_d   = rsp_ovf_q;
        rr_ptr_d    = rr_ptr_q;
        run_d       = 1'b1;

        // A flushed S1 entry is dropped rather than transferred.
        if (advance) begin
            rsp_valid_d = iss_v_q & ~iss_kill;
            if (iss_v_q && !iss_kill) begin
                rsp_tid_d  = iss_tid_q;
                rsp_data_d = alu_out;
                rsp_eq_d   = alu_eq;
                rsp_lt_d   = alu_lt;
                rsp_ovf_d  = alu_ovf;
            end
        end else begin
            rsp_valid_d = rsp_valid_q & ~rsp_kill;
        end

        // Operand fields only change on a grant, so idle ALU inputs stay quiet.
        if (s1_load) begin
            iss_v_d = accept;
            if (accept) begin
                iss_tid_d = gnt_idx;
                iss_req_d = win_req;
            end
        end else begin
            iss_v_d = iss_v_q & ~iss_kill;
        end

        if (accept) begin
            rr_ptr_d = (gnt_idx == TID_W'(NUM_THR - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_v_q     <= 1'b0;
            iss_tid_q   <= '0;
            iss_req_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= '0;
            rsp_data_q  <= '0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rr_ptr_q    <= '0;
            run_q       <= 1'b0;
        end else begin
            iss_v_q     <= iss_v_d;
            iss_tid_q   <= iss_tid_d;
            iss_req_q   <= iss_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_lt_q    <= rsp_lt_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rr_ptr_q    <= rr_ptr_d;
            run_q       <= run_d;
        end
    end

    assign alu_ain   = iss_req_q.a;
    assign alu_bin   = iss_req_q.b;
    assign alu_imm   = iss_req_q.imm;
    assign alu_op    = iss_req_q.op;
    assign alu_itype = iss_req_q.itype;

    assign rsp_valid = rsp_valid_q;
    assign rsp_tid   = rsp_tid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_lt    = rsp_lt_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_alu_issue_arb.sv
// Directed bench for alu_issue_arb with a behavioural ALU attached.
module tb_alu_issue_arb;
    import alu_issue_arb_pkg::*;

    localparam int unsigned NT = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NT-1:0]            req_valid = '0;
    logic [NT-1:0]            req_ready;
    logic [NT-1:0][31:0]      req_a = '0;
    logic [NT-1:0][31:0]      req_b = '0;
    logic [NT-1:0][15:0]      req_imm = '0;
    logic [NT-1:0][2:0]       req_op = '0;
    logic [NT-1:0]            req_itype = '0;
    logic [NT-1:0]            thr_en = '1;
    logic [NT-1:0]            flush = '0;
    logic [31:0]              alu_ain, alu_bin;
    logic [15:0]              alu_imm;
    logic [2:0]               alu_op;
    logic                     alu_itype;
    logic [31:0]              alu_out;
    logic                     alu_eq, alu_lt, alu_ovf;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b1;
    logic [1:0]               rsp_tid;
    logic [31:0]              rsp_data;
    logic                     rsp_eq, rsp_lt, rsp_ovf;

    int errors = 0;
    int checks = 0;

    alu_issue_arb #(.NUM_THR(NT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_imm   (req_imm),
        .req_op    (req_op),
        .req_itype (req_itype),
        .thr_en    (thr_en),
        .flush     (flush),
        .alu_ain   (alu_ain),
        .alu_bin   (alu_bin),
        .alu_imm   (alu_imm),
        .alu_op    (alu_op),
        .alu_itype (alu_itype),
        .alu_out   (alu_out),
        .alu_eq    (alu_eq),
        .alu_lt    (alu_lt),
        .alu_ovf   (alu_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tid   (rsp_tid),
        .rsp_data  (rsp_data),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: itype selects the sign-extended immediate as operand B.
    logic [31:0] bop, sum;
    always_comb begin
        bop     = alu_itype ? {{16{alu_imm[15]}}, alu_imm} : alu_bin;
        sum     = alu_ain + bop;
        alu_out = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_out = sum;
                alu_ovf = (alu_ain[31] == bop[31]) && (sum[31] != alu_ain[31]);
            end
            3'd1:    alu_out = alu_ain & bop;
            3'd2:    alu_out = alu_ain | bop;
            3'd3:    alu_out = alu_ain ^ bop;
            3'd4:    alu_out = ~alu_ain;
            3'd5:    alu_out = alu_ain << bop[4:0];
            3'd6:    alu_out = alu_ain >> bop[4:0];
            default: alu_out = $unsigned($signed(alu_ain) >>> bop[4:0]);
        endcase
        alu_eq = (alu_ain == bop);
        alu_lt = ($signed(alu_ain) < $signed(bop));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int t, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] imm, input logic it);
        req_valid[t] = 1'b1;
        req_op[t]    = op;
        req_a[t]     = a;
        req_b[t]     = b;
        req_imm[t]   = imm;
        req_itype[t] = it;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0;
        flush     = '0;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        int          tid;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic        itype;
        logic [31:0] data;
        logic        eq;
        logic        lt;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];
    int   rr_exp5[6];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2, AluAdd,  32'd5,          32'd7,          16'h0000, 1'b0, 32'd12,         1'b0, 1'b1, 1'b0};
        vecs[1] = '{0, AluAnd,  32'hF0F0_1234,  32'h0FF0_FFFF,  16'h0000, 1'b0, 32'h00F0_1234,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{1, AluOr,   32'h0000_00F0,  32'h0000_000F,  16'h0000, 1'b0, 32'h0000_00FF,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{3, AluXor,  32'h1234_5678,  32'h1234_5678,  16'h0000, 1'b0, 32'h0,          1'b1, 1'b0, 1'b0};
        vecs[4] = '{1, AluNot,  32'h0,          32'd3,          16'h0000, 1'b0, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0};
        vecs[5] = '{2, AluShlt, 32'd1,          32'd4,          16'h0000, 1'b0, 32'd16,         1'b0, 1'b1, 1'b0};
        vecs[6] = '{0, AluShrt, 32'h8000_0000,  32'd4,          16'h0000, 1'b0, 32'h0800_0000,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{3, AluShar, 32'h8000_0000,  32'd4,          16'h0000, 1'b0, 32'hF800_0000,  1'b0, 1'b1, 1'b0};
        vecs[8] = '{0, AluAdd,  32'h7FFF_FFFF,  32'd1,          16'h0000, 1'b0, 32'h8000_0000,  1'b0, 1'b0, 1'b1};
        vecs[9] = '{1, AluAdd,  32'd10,         32'd99,         16'hFFFF, 1'b1, 32'd9,          1'b0, 1'b0, 1'b0};
        rr_exp5 = '{0, 1, 3, 0, 1, 3};

        // Reset state, with every thread requesting.
        req_valid = '1;
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset rsp_tid", 32'(rsp_tid), 32'd0);
        chk("reset rsp_flags", {29'd0, rsp_eq, rsp_lt, rsp_ovf}, 32'd0);
        chk("reset alu_ain", alu_ain, 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        do_reset();

        // Single ops: accept, two-cycle latency, tagged result.
        for (int v = 0; v < 10; v++) begin
            int w;
            @(negedge clk);
            set_req(vecs[v].tid, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].imm, vecs[v].itype);
            #1;
            w = 0;
            while (!req_ready[vecs[v].tid] && w < 5) begin
                @(negedge clk);
                #1;
                w++;
            end
            chk($sformatf("v%0d accept", v), 32'(req_ready[vecs[v].tid]), 32'd1);
            @(negedge clk);
            req_valid = '0;
            #1;
            chk($sformatf("v%0d lat1 rsp_valid", v), 32'(rsp_valid), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d rsp_valid", v), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d rsp_tid", v), 32'(rsp_tid), 32'(vecs[v].tid));
            chk($sformatf("v%0d rsp_data", v), rsp_data, vecs[v].data);
            chk($sformatf("v%0d rsp_eq", v), 32'(rsp_eq), 32'(vecs[v].eq));
            chk($sformatf("v%0d rsp_lt", v), 32'(rsp_lt), 32'(vecs[v].lt));
            chk($sformatf("v%0d rsp_ovf", v), 32'(rsp_ovf), 32'(vecs[v].ovf));
        end
        drain();

        // All four threads requesting continuously from pointer 0.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                for (int t = 0; t < 4; t++) set_req(t, AluAdd, 32'(100 + t), 32'(t), 16'h0, 1'b0);
            end
            #1;
            chk($sformatf("rr k%0d req_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                chk($sformatf("rr k%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
                chk($sformatf("rr k%0d rsp_tid", k), 32'(rsp_tid), 32'((k - 2) % 4));
                chk($sformatf("rr k%0d rsp_data", k), rsp_data, 32'(100 + 2 * ((k - 2) % 4)));
            end
        end
        drain();

        // Backpressure with two ops in flight.
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, AluAdd, 32'd1, 32'd1, 16'h0, 1'b0);
        #1;
        chk("bp t0 ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        set_req(1, AluAdd, 32'd2, 32'd2, 16'h0, 1'b0);
        #1;
        chk("bp t1 ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        set_req(2, AluAdd, 32'd3, 32'd3, 16'h0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            chk($sformatf("bp hold%0d ready", s), 32'(req_ready), 32'd0);
            chk($sformatf("bp hold%0d valid", s), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp hold%0d tid", s), 32'(rsp_tid), 32'd0);
            chk($sformatf("bp hold%0d data", s), rsp_data, 32'd2);
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        chk("bp rel0 tid", 32'(rsp_tid), 32'd0);
        chk("bp rel0 data", rsp_data, 32'd2);
        @(negedge clk);
        #1;
        chk("bp rel1 valid", 32'(rsp_valid), 32'd1);
        chk("bp rel1 tid", 32'(rsp_tid), 32'd1);
        chk("bp rel1 data", rsp_data, 32'd4);
        @(negedge clk);
        #1;
        chk("bp empty", 32'(rsp_valid), 32'd0);
        drain();

        // Flush t1 in S1 while t3 sits in S2 and is consumed.
        @(negedge clk);
        set_req(3, AluAdd, 32'd30, 32'd3, 16'h0, 1'b0);
        #1;
        chk("flA t3 ready", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        set_req(1, AluAdd, 32'd10, 32'd1, 16'h0, 1'b0);
        #1;
        chk("flA t1 ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        flush = 4'b0010;
        #1;
        chk("flA t3 valid", 32'(rsp_valid), 32'd1);
        chk("flA t3 tid", 32'(rsp_tid), 32'd3);
        chk("flA t3 data", rsp_data, 32'd33);
        @(negedge clk);
        flush = '0;
        #1;
        chk("flA t1 dropped", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("flA t1 still gone", 32'(rsp_valid), 32'd0);
        drain();

        // Flush t1 stalled in S2 while t3 waits in S1.
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, AluAdd, 32'd10, 32'd1, 16'h0, 1'b0);
        #1;
        chk("flB t1 ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        set_req(3, AluAdd, 32'd30, 32'd3, 16'h0, 1'b0);
        #1;
        chk("flB t3 ready", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        flush = 4'b0010;
        #1;
        chk("flB t1 in S2", 32'(rsp_tid), 32'd1);
        @(negedge clk);
        flush = '0;
        #1;
        chk("flB t1 killed", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("flB t3 valid", 32'(rsp_valid), 32'd1);
        chk("flB t3 tid", 32'(rsp_tid), 32'd3);
        chk("flB t3 data", rsp_data, 32'd33);
        @(negedge clk);
        #1;
        chk("flB empty", 32'(rsp_valid), 32'd0);
        drain();

        // Thread 2 masked: rr order skips it.
        do_reset();
        thr_en = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                for (int t = 0; t < 4; t++) set_req(t, AluAdd, 32'(100 + t), 32'(t), 16'h0, 1'b0);
            end
            #1;
            chk($sformatf("mask k%0d req_ready", k), 32'(req_ready), 32'(1 << rr_exp5[k]));
        end
        drain();
        thr_en = '1;

        // Reset mid-flight: in-flight op vanishes and pointer returns to 0.
        @(negedge clk);
        set_req(2, AluAdd, 32'h7FFF_FFFF, 32'd1, 16'h0, 1'b0);
        #1;
        chk("rst t2 ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rst t2 issued", alu_ain, 32'h7FFF_FFFF);
        rst_n = 1'b0;
        for (int t = 0; t < 4; t++) set_req(t, AluAdd, 32'(100 + t), 32'(t), 16'h0, 1'b0);
        #1;
        chk("rst mid alu_ain", alu_ain, 32'd0);
        chk("rst mid req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst rel rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("rst rel ptr0 grant", 32'(req_ready), 32'b0001);
        chk("rst rel1 rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rst rel2 rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("rst new rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rst new rsp_tid", 32'(rsp_tid), 32'd0);
        chk("rst new rsp_data", rsp_data, 32'd100);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
